tt_pin_bus_responder: RTL and testbench

Register-file responder that sits behind the TinyTapeout user pins and answers a four-phase request/acknowledge handshake driven by the host: the cocotb bench or the demo-board MCU. The host presents a write or read command on `ui_in` and data on `uio_in`. The block synchronises the request, executes it against a small register file, raises an acknowledge, and drives read data back on `uio_out`. It is the device-side counterpart of the bench that drives `tt_um_BRS_2` pins. It is instantiated inside the top-level `tt_um_*` wrapper.

---
 rtl/tt_bus_pkg.sv | 24 ++
 rtl/tt_sync_bit.sv | 24 ++
 rtl/tt_pin_bus_responder.sv | 163 ++++++++++++++++
 tb/tb_tt_pin_bus_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_bus_pkg.sv
// rtl/tt_bus_pkg.sv - shared types and pin field positions for the pin bus responder
package tt_bus_pkg;

  localparam int ADDR_W = 4;

  // ui_in field positions
  localparam int UI_REQ      = 0;
  localparam int UI_WR       = 1;
  localparam int UI_ADDR_LSB = 2;
  localparam int UI_PAR      = 6;

  // uo_out field positions
  localparam int UO_ACK  = 7;
  localparam int UO_BUSY = 6;
  localparam int UO_ERR  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    EXEC    = 2'd2,
    ACK     = 2'd3
  } state_e;

endpackage

// File: rtl/tt_sync_bit.sv
// rtl/tt_sync_bit.sv - N-stage single-bit synchroniser, async active-low reset to 0
module tt_sync_bit #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] stages_q;

  // Shift the asynchronous input through N flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stages_q <= '0;
    end else begin
      stages_q <= {stages_q[N-2:0], d_i};
    end
  end

  assign q_o = stages_q[N-1];

endmodule

// File: rtl/tt_pin_bus_responder.sv
// rtl/tt_pin_bus_responder.sv - four-phase req/ack register-file responder on TinyTapeout pins; optional BUS_PARITY_EN
module tt_pin_bus_responder
  import tt_bus_pkg::*;
#(
  parameter int          NREGS       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  ID_VALUE    = 8'hB5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e              state_q, state_d;
  logic                req_s;
  logic                armed_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          data_q;
  logic [7:0]          rdata_q;
  logic [7:0]          regs_q [1:NREGS-1];
  logic [7:0]          rd_val;
  logic                wr_allow;
  logic                ack;
  logic                busy;

`ifdef BUS_PARITY_EN
  logic                par_err_q;
  logic                err_q;
  assign wr_allow = ~par_err_q;
`else
  assign wr_allow = 1'b1;
`endif

  tt_sync_bit #(.N(SYNC_STAGES)) u_req_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (ui_in[UI_REQ]),
    .q_o    (req_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; deselecting the design always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (req_s && armed_q) state_d = CAPTURE;
        CAPTURE: state_d = EXEC;
        EXEC:    state_d = ACK;
        ACK:     if (!req_s) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: handshake flags and read-data drive enable
  always_comb begin
    ack    = 1'b0;
    busy   = 1'b0;
    uio_oe = 8'h00;
    if (state_q != IDLE) busy = 1'b1;
    if (state_q == ACK) begin
      ack = 1'b1;
      if (!wr_q) uio_oe = 8'hFF;
    end
  end

  // Armed: a new transaction needs req_s seen low in IDLE since the last one started
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b1;
    end else if (state_q == IDLE) begin
      if (!req_s) begin
        armed_q <= 1'b1;
      end else if (state_d == CAPTURE) begin
        armed_q <= 1'b0;
      end
    end
  end

  // Read mux: reg0 is the ID constant, out-of-range addresses read as zero
  always_comb begin
    rd_val = 8'h00;
    if (addr_q == '0) begin
      rd_val = ID_VALUE;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (addr_q == ADDR_W'(i)) rd_val = regs_q[i];
      end
    end
  end

  // Datapath: capture the command, then execute it against the register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 8'h00;
      rdata_q <= 8'h00;
      for (int i = 1; i < NREGS; i++) regs_q[i] <= 8'h00;
`ifdef BUS_PARITY_EN
      par_err_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else if (ena) begin
      if (state_q == CAPTURE) begin
        wr_q   <= ui_in[UI_WR];
        addr_q <= ui_in[UI_ADDR_LSB +: ADDR_W];
        data_q <= uio_in;
`ifdef BUS_PARITY_EN
        par_err_q <= ui_in[UI_PAR] ^ (^{ui_in[UI_WR], ui_in[UI_ADDR_LSB +: ADDR_W], uio_in});
`endif
      end else if (state_q == EXEC) begin
        if (wr_q) begin
          // Address 0 never matches the loop, so reg0 stays read-only
          if (wr_allow) begin
            for (int i = 1; i < NREGS; i++) begin
              if (addr_q == ADDR_W'(i)) regs_q[i] <= data_q;
            end
          end
`ifdef BUS_PARITY_EN
          if (par_err_q) err_q <= 1'b1;
`endif
        end else begin
          rdata_q <= rd_val;
`ifdef BUS_PARITY_EN
          if (addr_q == '0) err_q <= 1'b0;
`endif
        end
      end
    end
  end

  // Output pin assembly
  always_comb begin
    uo_out          = 8'h00;
    uo_out[UO_ACK]  = ack;
    uo_out[UO_BUSY] = busy;
    uo_out[5:0]     = regs_q[1][5:0];
`ifdef BUS_PARITY_EN
    uo_out[UO_ERR]  = err_q;
`endif
  end

  assign uio_out = rdata_q;

endmodule

// File: tb/tb_tt_pin_bus_responder.sv
// tb/tb_tt_pin_bus_responder.sv - self-checking bench for tt_pin_bus_responder
module tb_tt_pin_bus_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_regs [16];
  logic       model_err;

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  tt_pin_bus_responder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    model_err = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input logic [3:0] a);
    if (a == 4'd0) return 8'hB5;
    if (a >= 4'd8) return 8'h00;
    return model_regs[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete four-phase transaction, checked against the model
  task automatic txn(input logic wr, input logic [3:0] addr, input logic [7:0] data,
                     input logic bad_par, output logic [7:0] rd);
    int         n;
    logic       drop;
    logic [5:0] exp_low;
    ui_in  = {1'b0, (^{wr, addr, data}) ^ bad_par, addr, wr, 1'b1};
    uio_in = data;
    n = 0;
    while (uo_out[7] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("ack_latency", n, 5);
    drop = 1'b0;
`ifdef BUS_PARITY_EN
    drop = bad_par;
`endif
    if (wr) begin
      if (drop) model_err = 1'b1;
      else if (addr != 4'd0 && addr < 4'd8) model_regs[addr] = data;
    end else if (addr == 4'd0) begin
      model_err = 1'b0;
    end
    exp_low = model_regs[1][5:0];
`ifdef BUS_PARITY_EN
    exp_low[5] = model_err;
`endif
    check("reg1_at_ack", uo_out[5:0], exp_low);
    check("busy_at_ack", uo_out[6], 1);
    if (wr) begin
      check("oe_write", uio_oe, 8'h00);
    end else begin
      check("rdata", uio_out, model_read(addr));
      check("oe_read", uio_oe, 8'hFF);
    end
    rd = uio_out;
    ui_in[0] = 1'b0;
    n = 0;
    while (uo_out[7] !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("ack_fall", n, 3);
    check("oe_after", uio_oe, 8'h00);
    check("busy_after", uo_out[6], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    int         n;
    logic       busy_seen;

    vecs[0] = '{1'b1, 4'd1,  8'h3C, 8'h00};
    vecs[1] = '{1'b0, 4'd1,  8'h00, 8'h3C};
    vecs[2] = '{1'b1, 4'd0,  8'h77, 8'h00};
    vecs[3] = '{1'b0, 4'd0,  8'h00, 8'hB5};
    vecs[4] = '{1'b1, 4'd12, 8'h77, 8'h00};
    vecs[5] = '{1'b0, 4'd12, 8'h00, 8'h00};
    vecs[6] = '{1'b1, 4'd7,  8'hA5, 8'h00};
    vecs[7] = '{1'b0, 4'd7,  8'h00, 8'hA5};
    vecs[8] = '{1'b0, 4'd15, 8'h00, 8'h00};
    vecs[9] = '{1'b0, 4'd2,  8'h00, 8'h00};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    repeat (3) tick();
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
    tick();
    check("post_rst_uo_out", uo_out, 8'h00);

    txn(1'b0, 4'd0, 8'h00, 1'b0, rd);
    check("id_read", rd, 8'hB5);

    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, rd);
      if (!vecs[i].wr) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
    end
    check("reg1_pins", uo_out[5:0], 6'h3C);

    // Deselect during ACK, then keep req high: no new transaction
    ui_in  = {1'b0, ^{1'b0, 4'd3, 8'h00}, 4'd3, 1'b0, 1'b1};
    uio_in = 8'h00;
    n = 0;
    while (uo_out[7] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("ena_ack_reached", n, 5);
    ena = 1'b0;
    tick();
    check("ena_ack_clear", uo_out[7], 0);
    check("ena_oe_clear", uio_oe, 8'h00);
    check("ena_busy_clear", uo_out[6], 0);
    ena = 1'b1;
    busy_seen = 1'b0;
    repeat (10) begin
      tick();
      if (uo_out[6] === 1'b1) busy_seen = 1'b1;
    end
    check("no_restart", busy_seen, 0);
    ui_in[0] = 1'b0;
    repeat (4) tick();
    txn(1'b0, 4'd1, 8'h00, 1'b0, rd);
    check("retained_reg1", rd, 8'h3C);

    // Reset in CAPTURE of a write of 0xAA to addr 2
    ui_in  = {1'b0, ^{1'b1, 4'd2, 8'hAA}, 4'd2, 1'b1, 1'b1};
    uio_in = 8'hAA;
    repeat (3) tick();
    check("capture_busy", uo_out[6], 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_uo_out", uo_out, 8'h00);
    check("async_rst_oe", uio_oe, 8'h00);
    model_reset();
    ui_in = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    txn(1'b0, 4'd2, 8'h00, 1'b0, rd);
    check("aborted_write", rd, 8'h00);

`ifdef BUS_PARITY_EN
    txn(1'b1, 4'd1, 8'h01, 1'b1, rd);
    check("par_err_flag", uo_out[5], 1);
    check("par_reg1_kept", uo_out[4:0], 5'h00);
    txn(1'b0, 4'd0, 8'h00, 1'b0, rd);
    check("par_err_cleared", uo_out[5], 0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic       r_wr;
      logic [3:0] r_addr;
      logic [7:0] r_data;
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = 4'($urandom_range(0, 15));
      r_data = 8'($urandom);
      txn(r_wr, r_addr, r_data, 1'b0, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
